uart_rx: RTL and testbench

AXI4-Stream UART receiver. It deserialises 8N1-style frames from the `rxd` line and presents each byte on an AXI4-Stream master port. It is the receive-direction counterpart of the team's AXI-Stream UART transmitter, and sits between the external serial pin and the downstream stream consumer. It reports `rx_busy`, overrun and framing status on the same signal set the verification interface already carries.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM encoding, oversampling ratio
// and the bit-period arithmetic derived from the prescale input.
package uart_pkg;

    localparam int OVERSAMPLE = 8;
    localparam int HALF_BIT   = 4;
    localparam int PRESCALE_W = 16;
    localparam int CNT_W      = PRESCALE_W + 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // A prescale of zero would stall the bit timer forever, so it counts as one.
    function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
        return (p == '0) ? PRESCALE_W'(1) : p;
    endfunction

    function automatic logic [CNT_W-1:0] half_bit_cnt(input logic [PRESCALE_W-1:0] p);
        return CNT_W'(p) * CNT_W'(HALF_BIT);
    endfunction

    function automatic logic [CNT_W-1:0] full_bit_cnt(input logic [PRESCALE_W-1:0] p);
        return CNT_W'(p) * CNT_W'(OVERSAMPLE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value
// so an idle-high line does not look like activity when reset is released.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments so each flop samples the pre-edge value of the one before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// AXI4-Stream UART receiver: samples 8N1-style frames at mid-bit using a
// prescale-derived timer and presents each byte through a one-entry output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  rx_busy,
    output logic                  rx_overrun_error,
    output logic                  rx_frame_error,
    input  logic [PRESCALE_W-1:0] prescale
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    rx_state_t               state_q, state_d;
    logic [PRESCALE_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    busy_q, busy_d;
    logic                    ovr_q, ovr_d;
    logic                    ferr_q, ferr_d;
    logic                    rxd_prev_q;

    logic                    rxd_s;
    logic                    tick;
    logic                    start_edge;
    logic                    byte_done;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rxd_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    // The timer is loaded with the interval length and samples when it reaches one.
    assign tick       = (cnt_q == CNT_W'(1));
    assign start_edge = rxd_prev_q & ~rxd_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    p_d     = eff_prescale(prescale);
                    cnt_d   = half_bit_cnt(p_d);
                    state_d = START;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rxd_s) begin
                    cnt_d   = full_bit_cnt(p_q);
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = full_bit_cnt(p_q);
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_done = (state_q == STOP) && tick && rxd_s;
        ferr_d    = (state_q == STOP) && tick && !rxd_s;
        busy_d    = (state_d != IDLE);
        ovr_d     = 1'b0;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        // A full register that is not being drained keeps its byte; the new one is lost.
        if (byte_done) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = shift_q;
                tvalid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q        <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            rxd_prev_q <= 1'b1;
        end else begin
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            rxd_prev_q <= rxd_s;
        end
    end

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign rx_busy          = busy_q;
    assign rx_overrun_error = ovr_q;
    assign rx_frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-timing model derived from the bit-period arithmetic.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int W        = 8;
    localparam int SYNC_DLY = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [W-1:0]          m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready = 1'b0;
    logic                  rxd = 1'b1;
    logic                  rx_busy;
    logic                  rx_overrun_error;
    logic                  rx_frame_error;
    logic [PRESCALE_W-1:0] prescale = 16'd1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int busy_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, stab_viol = 0;
    logic [W-1:0] beat_data[$];
    int           rise_cyc[$];
    logic         prev_valid = 1'b0, prev_ready = 1'b0;
    logic [W-1:0] prev_data = '0;

    uart_rx #(.DATA_WIDTH(W)) dut (
        .clk              (clk),
        .rst              (rst),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .rxd              (rxd),
        .rx_busy          (rx_busy),
        .rx_overrun_error (rx_overrun_error),
        .rx_frame_error   (rx_frame_error),
        .prescale         (prescale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observes outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) beat_data.push_back(m_axis_tdata);
        if (m_axis_tvalid && !prev_valid) rise_cyc.push_back(cyc);
        if (prev_valid && !prev_ready && m_axis_tvalid && (m_axis_tdata !== prev_data)) stab_viol++;
        if (rx_frame_error) ferr_cnt++;
        if (rx_overrun_error) ovr_cnt++;
        if (rx_busy) busy_cnt++;
        prev_valid = m_axis_tvalid;
        prev_ready = m_axis_tready;
        prev_data  = m_axis_tdata;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference timing model: cycles of rx_busy per frame and the delay from
    // driving the start bit to tvalid rising.
    function automatic int peff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic int model_busy(input int p);
        return peff(p) * (HALF_BIT + OVERSAMPLE * (W + 1));
    endfunction

    function automatic int model_latency(input int p);
        return SYNC_DLY + model_busy(p) + 1;
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] b, input int p, input logic stop_val,
                              input bit scramble, output int c0);
        int per;
        per      = OVERSAMPLE * peff(p);
        prescale = 16'(p);
        rxd      = 1'b0;
        c0       = cyc;
        tick_n(per);
        if (scramble) prescale = 16'($urandom_range(0, 7));
        for (int i = 0; i < W; i++) begin
            rxd = b[i];
            tick_n(per);
        end
        rxd = stop_val;
        tick_n(per);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rxd = 1'b1;
        tick_n(3);
        n_checks++;
        if ({m_axis_tdata, m_axis_tvalid, rx_busy, rx_overrun_error, rx_frame_error} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got tdata=%h tvalid=%b busy=%b ovr=%b ferr=%b, want all 0",
                     m_axis_tdata, m_axis_tvalid, rx_busy, rx_overrun_error, rx_frame_error);
        end
        rst = 1'b1;
        tick_n(5);
        n_checks++;
        if ({m_axis_tvalid, rx_busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_release_idle: got tvalid=%b busy=%b, want 0 0", m_axis_tvalid, rx_busy);
        end
    endtask

    task automatic test_basic();
        int nb, nr, nbusy, nf, no, c0;
        m_axis_tready = 1'b1;
        tick_n(5);
        nb = beat_data.size(); nr = rise_cyc.size(); nbusy = busy_cnt; nf = ferr_cnt; no = ovr_cnt;
        send_frame(8'hA5, 1, 1'b1, 1'b0, c0);
        tick_n(20);
        n_checks++;
        if (beat_data.size() - nb !== 1) begin
            n_errors++;
            $display("FAIL basic_beats: got %0d beats, want 1", beat_data.size() - nb);
        end else begin
            n_checks++;
            if (beat_data[nb] !== 8'hA5) begin
                n_errors++;
                $display("FAIL basic_data: got %h, want a5", beat_data[nb]);
            end
        end
        n_checks++;
        if (rise_cyc.size() <= nr) begin
            n_errors++;
            $display("FAIL basic_latency: tvalid never rose, want 77 clocks after rxd_s falls");
        end else if (rise_cyc[nr] - c0 - SYNC_DLY !== 77) begin
            n_errors++;
            $display("FAIL basic_latency: got %0d, want 77", rise_cyc[nr] - c0 - SYNC_DLY);
        end
        n_checks++;
        if (busy_cnt - nbusy !== 76) begin
            n_errors++;
            $display("FAIL basic_busy: got %0d cycles, want 76", busy_cnt - nbusy);
        end
        n_checks++;
        if ((ferr_cnt - nf) + (ovr_cnt - no) !== 0) begin
            n_errors++;
            $display("FAIL basic_errors: got ferr=%0d ovr=%0d, want 0 0", ferr_cnt - nf, ovr_cnt - no);
        end
    endtask

    task automatic test_overrun();
        int nb, no, ns, c0;
        m_axis_tready = 1'b0;
        tick_n(5);
        nb = beat_data.size(); no = ovr_cnt; ns = stab_viol;
        send_frame(8'h3C, 4, 1'b1, 1'b0, c0);
        tick_n(10);
        n_checks++;
        if (ovr_cnt - no !== 0) begin
            n_errors++;
            $display("FAIL overrun_first_frame: got %0d pulses, want 0", ovr_cnt - no);
        end
        send_frame(8'hC3, 4, 1'b1, 1'b0, c0);
        tick_n(40);
        n_checks++;
        if (ovr_cnt - no !== 1) begin
            n_errors++;
            $display("FAIL overrun_pulse: got %0d pulses, want 1", ovr_cnt - no);
        end
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'h3C}) begin
            n_errors++;
            $display("FAIL overrun_hold: got tvalid=%b tdata=%h, want 1 3c", m_axis_tvalid, m_axis_tdata);
        end
        n_checks++;
        if (stab_viol - ns !== 0) begin
            n_errors++;
            $display("FAIL overrun_stability: got %0d tdata changes while stalled, want 0", stab_viol - ns);
        end
        m_axis_tready = 1'b1;
        tick_n(5);
        n_checks++;
        if (beat_data.size() - nb !== 1) begin
            n_errors++;
            $display("FAIL overrun_drain_beats: got %0d, want 1", beat_data.size() - nb);
        end else begin
            n_checks++;
            if (beat_data[nb] !== 8'h3C) begin
                n_errors++;
                $display("FAIL overrun_drain_data: got %h, want 3c", beat_data[nb]);
            end
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_tvalid_fall: got %b, want 0", m_axis_tvalid);
        end
    endtask

    task automatic test_frame_error();
        int nb, nf, no, c0;
        m_axis_tready = 1'b1;
        tick_n(5);
        nb = beat_data.size(); nf = ferr_cnt; no = ovr_cnt;
        send_frame(8'h55, 2, 1'b0, 1'b0, c0);
        tick_n(20);
        n_checks++;
        if (ferr_cnt - nf !== 1) begin
            n_errors++;
            $display("FAIL ferr_pulse: got %0d pulses, want 1", ferr_cnt - nf);
        end
        n_checks++;
        if ((beat_data.size() - nb !== 0) || (m_axis_tvalid !== 1'b0)) begin
            n_errors++;
            $display("FAIL ferr_no_output: got %0d beats tvalid=%b, want 0 0", beat_data.size() - nb, m_axis_tvalid);
        end
        // A line held low for several frame times is one break, not repeated frames.
        prescale = 16'd2;
        rxd = 1'b0;
        tick_n(500);
        rxd = 1'b1;
        tick_n(20);
        n_checks++;
        if (ferr_cnt - nf !== 2) begin
            n_errors++;
            $display("FAIL break_single_error: got %0d total pulses, want 2", ferr_cnt - nf);
        end
        send_frame(8'h81, 2, 1'b1, 1'b0, c0);
        tick_n(20);
        n_checks++;
        if (beat_data.size() - nb !== 1) begin
            n_errors++;
            $display("FAIL ferr_recover_beats: got %0d, want 1", beat_data.size() - nb);
        end else begin
            n_checks++;
            if (beat_data[nb] !== 8'h81) begin
                n_errors++;
                $display("FAIL ferr_recover_data: got %h, want 81", beat_data[nb]);
            end
        end
        n_checks++;
        if ((ferr_cnt - nf !== 2) || (ovr_cnt - no !== 0)) begin
            n_errors++;
            $display("FAIL ferr_recover_errors: got ferr=%0d ovr=%0d, want 2 0", ferr_cnt - nf, ovr_cnt - no);
        end
    endtask

    task automatic test_false_start();
        int nb, nbusy, nf, no;
        tick_n(5);
        nb = beat_data.size(); nbusy = busy_cnt; nf = ferr_cnt; no = ovr_cnt;
        prescale = 16'd2;
        rxd = 1'b0;
        tick_n(3);
        rxd = 1'b1;
        tick_n(40);
        n_checks++;
        if (busy_cnt - nbusy !== 8) begin
            n_errors++;
            $display("FAIL false_start_busy: got %0d cycles, want 8", busy_cnt - nbusy);
        end
        n_checks++;
        if ((beat_data.size() - nb) + (ferr_cnt - nf) + (ovr_cnt - no) !== 0) begin
            n_errors++;
            $display("FAIL false_start_quiet: got beats=%0d ferr=%0d ovr=%0d, want 0 0 0",
                     beat_data.size() - nb, ferr_cnt - nf, ovr_cnt - no);
        end
    endtask

    task automatic test_prescale_zero();
        int nb, nr, nbusy, c0;
        tick_n(5);
        nb = beat_data.size(); nr = rise_cyc.size(); nbusy = busy_cnt;
        send_frame(8'hFF, 0, 1'b1, 1'b0, c0);
        tick_n(20);
        n_checks++;
        if (beat_data.size() - nb !== 1) begin
            n_errors++;
            $display("FAIL pz_beats: got %0d, want 1", beat_data.size() - nb);
        end else begin
            n_checks++;
            if (beat_data[nb] !== 8'hFF) begin
                n_errors++;
                $display("FAIL pz_data: got %h, want ff", beat_data[nb]);
            end
        end
        n_checks++;
        if (rise_cyc.size() <= nr) begin
            n_errors++;
            $display("FAIL pz_latency: tvalid never rose, want 77");
        end else if (rise_cyc[nr] - c0 - SYNC_DLY !== 77) begin
            n_errors++;
            $display("FAIL pz_latency: got %0d, want 77", rise_cyc[nr] - c0 - SYNC_DLY);
        end
        n_checks++;
        if (busy_cnt - nbusy !== 76) begin
            n_errors++;
            $display("FAIL pz_busy: got %0d, want 76", busy_cnt - nbusy);
        end
    endtask

    task automatic test_reset_abort();
        int nb, nf, no, c0;
        logic [W-1:0] aborted;
        aborted = 8'hAB;
        m_axis_tready = 1'b1;
        tick_n(5);
        prescale = 16'd2;
        rxd = 1'b0;
        tick_n(16);
        for (int i = 0; i < 4; i++) begin
            rxd = aborted[i];
            tick_n(16);
        end
        rxd = aborted[4];
        tick_n(8);
        rst = 1'b0;
        rxd = 1'b1;
        #1;
        n_checks++;
        if ({m_axis_tdata, m_axis_tvalid, rx_busy, rx_overrun_error, rx_frame_error} !== '0) begin
            n_errors++;
            $display("FAIL abort_reset_outputs: got tdata=%h tvalid=%b busy=%b, want all 0",
                     m_axis_tdata, m_axis_tvalid, rx_busy);
        end
        tick_n(5);
        nb = beat_data.size(); nf = ferr_cnt; no = ovr_cnt;
        rst = 1'b1;
        tick_n(30);
        send_frame(8'h12, 2, 1'b1, 1'b0, c0);
        tick_n(20);
        n_checks++;
        if (beat_data.size() - nb !== 1) begin
            n_errors++;
            $display("FAIL abort_beats: got %0d, want 1", beat_data.size() - nb);
        end else begin
            n_checks++;
            if (beat_data[nb] !== 8'h12) begin
                n_errors++;
                $display("FAIL abort_data: got %h, want 12", beat_data[nb]);
            end
        end
        n_checks++;
        if ((ferr_cnt - nf) + (ovr_cnt - no) !== 0) begin
            n_errors++;
            $display("FAIL abort_errors: got ferr=%0d ovr=%0d, want 0 0", ferr_cnt - nf, ovr_cnt - no);
        end
    endtask

    // Random bytes and bit rates, with prescale scrambled mid-frame to show it is latched at start.
    task automatic test_random();
        int nb, nr, c0, p;
        logic [W-1:0] b;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick_n(3 + $urandom_range(0, 20));
            p  = $urandom_range(0, 3);
            b  = W'($urandom);
            nb = beat_data.size(); nr = rise_cyc.size();
            send_frame(b, p, 1'b1, 1'b1, c0);
            tick_n(4);
            n_checks++;
            if (beat_data.size() - nb !== 1) begin
                n_errors++;
                $display("FAIL rand_beats[%0d]: got %0d, want 1 (p=%0d)", k, beat_data.size() - nb, p);
            end else if (beat_data[nb] !== b) begin
                n_errors++;
                $display("FAIL rand_data[%0d]: got %h, want %h (p=%0d)", k, beat_data[nb], b, p);
            end
            n_checks++;
            if (rise_cyc.size() <= nr) begin
                n_errors++;
                $display("FAIL rand_latency[%0d]: tvalid never rose, want %0d", k, model_latency(p));
            end else if (rise_cyc[nr] - c0 !== model_latency(p)) begin
                n_errors++;
                $display("FAIL rand_latency[%0d]: got %0d, want %0d", k, rise_cyc[nr] - c0, model_latency(p));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_error();
        test_false_start();
        test_prescale_zero();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
